// File: rtl/base_req_hold_if.sv
// ----------------------------------------------------------------------------
// base_req_hold_if : request/grant bundle between requesters and the encoder.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface base_req_hold_if #(
  parameter int WAYS = 2
);
  logic [0:WAYS-1] i_v;
  logic [0:WAYS-1] o_r;
  logic [0:WAYS-1] o_req;
  logic [0:WAYS-1] i_gnt;
  logic [0:WAYS-1] o_done;
  logic            o_any;
  logic            o_err;

  modport master (
    output i_v, i_gnt,
    input  o_r, o_req, o_done, o_any, o_err
  );

  modport slave (
    input  i_v, i_gnt,
    output o_r, o_req, o_done, o_any, o_err
  );
endinterface

`default_nettype wire

// File: rtl/base_req_hold.sv
// ----------------------------------------------------------------------------
// base_req_hold : per-way outstanding-request counters feeding a priority
//                 encoder, retiring one request per grant, sticky error flag.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module base_req_hold #(
  parameter int WAYS = 2,
  parameter int CNTW = 2
) (
  input  wire logic         clk,
  input  wire logic         reset,
  base_req_hold_if.slave    bus
);

  localparam logic [CNTW-1:0] c_max = '1;

  logic [CNTW-1:0] cnt_q [WAYS];
  logic [CNTW-1:0] cnt_d [WAYS];
  logic [0:WAYS-1] done_q;
  logic            err_q;

  logic [0:WAYS-1] w_rdy;
  logic [0:WAYS-1] w_req;
  logic [0:WAYS-1] w_inc;
  logic [0:WAYS-1] w_dec;
  logic            w_ovf;
  logic            w_idle;
  logic            w_multi;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    assign w_rdy[w] = (cnt_q[w] != c_max);
    assign w_req[w] = (cnt_q[w] != '0);
  end

  assign w_inc   = bus.i_v & w_rdy;
  assign w_dec   = bus.i_gnt & w_req;
  assign w_ovf   = |(bus.i_v & ~w_rdy);
  assign w_idle  = |(bus.i_gnt & ~w_req);
  assign w_multi = ($countones(bus.i_gnt) > 1);

  // Simultaneous accept and retire on one way cancel out.
  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      cnt_d[w] = cnt_q[w];
      if (w_inc[w] && !w_dec[w]) begin
        cnt_d[w] = cnt_q[w] + CNTW'(1);
      end else if (!w_inc[w] && w_dec[w]) begin
        cnt_d[w] = cnt_q[w] - CNTW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int w = 0; w < WAYS; w++) begin
        cnt_q[w] <= '0;
      end
      done_q <= '0;
      err_q  <= 1'b0;
    end else begin
      for (int w = 0; w < WAYS; w++) begin
        cnt_q[w] <= cnt_d[w];
      end
      done_q <= w_dec;
      err_q  <= err_q | w_ovf | w_idle | w_multi;
    end
  end

  assign bus.o_r    = w_rdy;
  assign bus.o_req  = w_req;
  assign bus.o_any  = |w_req;
  assign bus.o_done = done_q;
  assign bus.o_err  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_base_req_hold.sv
// ----------------------------------------------------------------------------
// tb_base_req_hold : vector table, corner sequence and random run vs a model.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_base_req_hold;

  localparam int WAYS = 2;
  localparam int CNTW = 2;
  localparam int MAXC = (1 << CNTW) - 1;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  base_req_hold_if #(.WAYS(WAYS)) bus ();

  base_req_hold #(.WAYS(WAYS), .CNTW(CNTW)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: outstanding count per way as plain integers.
  int          m_cnt [WAYS];
  logic        m_err;
  logic [0:1]  m_done;

  typedef struct {
    logic       r;
    logic [0:1] v;
    logic [0:1] g;
    logic [0:1] e_r;
    logic [0:1] e_req;
    logic [0:1] e_done;
    logic       e_err;
  } vec_t;

  vec_t tbl [$];

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic [0:1] v, input logic [0:1] g);
    int   ng;
    logic nerr;
    if (r) begin
      for (int w = 0; w < WAYS; w++) m_cnt[w] = 0;
      m_err  = 1'b0;
      m_done = '0;
    end else begin
      nerr = m_err;
      ng   = 0;
      for (int w = 0; w < WAYS; w++) ng += int'(g[w]);
      if (ng > 1) nerr = 1'b1;
      for (int w = 0; w < WAYS; w++) begin
        int acc, gr;
        acc = (v[w] && m_cnt[w] < MAXC) ? 1 : 0;
        gr  = (g[w] && m_cnt[w] > 0) ? 1 : 0;
        if (v[w] && acc == 0) nerr = 1'b1;
        if (g[w] && m_cnt[w] == 0) nerr = 1'b1;
        m_done[w] = (gr == 1);
        m_cnt[w]  = m_cnt[w] + acc - gr;
      end
      m_err = nerr;
    end
  endtask

  task automatic cycle(input logic r, input logic [0:1] v, input logic [0:1] g);
    rst       = r;
    bus.i_v   = v;
    bus.i_gnt = g;
    model_step(r, v, g);
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    logic [0:1] er, eq;
    for (int w = 0; w < WAYS; w++) begin
      er[w] = (m_cnt[w] != MAXC);
      eq[w] = (m_cnt[w] != 0);
    end
    chk({tag, ".o_r"},    bus.o_r,    er);
    chk({tag, ".o_req"},  bus.o_req,  eq);
    chk({tag, ".o_done"}, bus.o_done, m_done);
    chk({tag, ".o_any"},  {1'b0, bus.o_any}, {1'b0, |eq});
    chk({tag, ".o_err"},  {1'b0, bus.o_err}, {1'b0, m_err});
  endtask

  task automatic add(input logic r, input logic [0:1] v, input logic [0:1] g,
                     input logic [0:1] er, input logic [0:1] eq,
                     input logic [0:1] ed, input logic ee);
    vec_t t;
    t.r = r; t.v = v; t.g = g; t.e_r = er; t.e_req = eq; t.e_done = ed; t.e_err = ee;
    tbl.push_back(t);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [0:1] v, g;
    total = 0;
    bad   = 0;
    rst = 1'b1; bus.i_v = '0; bus.i_gnt = '0;
    for (int w = 0; w < WAYS; w++) m_cnt[w] = 0;
    m_err = 1'b0; m_done = '0;

    //   r  v      g      o_r    o_req  o_done err
    add(1, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 0);
    for (int i = 0; i < 5; i++) add(0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 0);
    add(0, 2'b10, 2'b00, 2'b11, 2'b10, 2'b00, 0);
    add(0, 2'b10, 2'b00, 2'b11, 2'b10, 2'b00, 0);
    add(0, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00, 0);
    add(0, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00, 1);
    add(0, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 1);
    add(1, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 0);
    add(0, 2'b11, 2'b00, 2'b11, 2'b11, 2'b00, 0);
    add(0, 2'b01, 2'b00, 2'b11, 2'b11, 2'b00, 0);
    add(0, 2'b00, 2'b10, 2'b11, 2'b01, 2'b10, 0);
    add(0, 2'b00, 2'b01, 2'b11, 2'b01, 2'b01, 0);
    add(0, 2'b00, 2'b01, 2'b11, 2'b00, 2'b01, 0);
    add(0, 2'b01, 2'b00, 2'b11, 2'b01, 2'b00, 0);
    add(0, 2'b01, 2'b01, 2'b11, 2'b01, 2'b01, 0);
    add(0, 2'b00, 2'b01, 2'b11, 2'b00, 2'b01, 0);
    add(0, 2'b00, 2'b01, 2'b11, 2'b00, 2'b00, 1);
    add(0, 2'b11, 2'b00, 2'b11, 2'b11, 2'b00, 1);
    add(0, 2'b00, 2'b11, 2'b11, 2'b00, 2'b11, 1);
    add(0, 2'b11, 2'b00, 2'b11, 2'b11, 2'b00, 1);
    add(0, 2'b11, 2'b00, 2'b11, 2'b11, 2'b00, 1);
    add(1, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 0);
    add(0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 0);

    foreach (tbl[i]) begin
      cycle(tbl[i].r, tbl[i].v, tbl[i].g);
      chk($sformatf("vec%0d.o_r", i),    bus.o_r,    tbl[i].e_r);
      chk($sformatf("vec%0d.o_req", i),  bus.o_req,  tbl[i].e_req);
      chk($sformatf("vec%0d.o_done", i), bus.o_done, tbl[i].e_done);
      chk($sformatf("vec%0d.o_any", i),  {1'b0, bus.o_any}, {1'b0, |tbl[i].e_req});
      chk($sformatf("vec%0d.o_err", i),  {1'b0, bus.o_err}, {1'b0, tbl[i].e_err});
    end

    // Way1 full: a request and a grant together retire one and drop the request.
    cycle(1, 2'b00, 2'b00);
    for (int i = 0; i < 3; i++) cycle(0, 2'b01, 2'b00);
    chk("full.o_r", bus.o_r, 2'b10);
    cycle(0, 2'b01, 2'b01);
    chk("fullgnt.o_done", bus.o_done, 2'b01);
    chk("fullgnt.o_r",    bus.o_r,    2'b11);
    chk("fullgnt.o_err",  {1'b0, bus.o_err}, 2'b01);
    cycle(0, 2'b00, 2'b01);
    cycle(0, 2'b00, 2'b01);
    chk("drain.o_req", bus.o_req, 2'b00);

    // Random run: mostly legal highest-priority grants, some illegal, rare reset.
    cycle(1, 2'b00, 2'b00);
    for (int n = 0; n < 600; n++) begin
      logic r;
      v = 2'($urandom_range(0, 3));
      g = '0;
      if ($urandom_range(0, 9) == 0) begin
        g = 2'($urandom_range(0, 3));
      end else if ($urandom_range(0, 2) != 0) begin
        for (int w = 0; w < WAYS; w++) begin
          if (m_cnt[w] != 0 && g == '0) g[w] = 1'b1;
        end
      end
      r = ($urandom_range(0, 59) == 0);
      cycle(r, v, g);
      check_model($sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
